// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the register file write port, with two bypass lookups.
// Define WBQ_COALESCE_EN to merge requests into a pending entry for the same dest.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_dest,
  input  logic [15:0] in_data,
  input  logic        wb_hold,
  output logic        reg_write_en,
  output logic [3:0]  reg_write_dest,
  output logic [15:0] reg_write_data,
  input  logic [3:0]  lookup_addr_1,
  output logic        lookup_hit_1,
  output logic [15:0] lookup_data_1,
  input  logic [3:0]  lookup_addr_2,
  output logic        lookup_hit_2,
  output logic [15:0] lookup_data_2,
  output logic        empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    dest_q [DEPTH];
  logic [15:0]   data_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          full, pop, push, coal;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // in_ready depends on stored state (plus in_dest when coalescing), never on in_valid.
  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && !wb_hold;

`ifdef WBQ_COALESCE_EN
  logic          match_any;
  logic [AW-1:0] match_idx;

  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((AW+1)'(i) < count) && (in_dest != 4'd0) &&
          (dest_q[rd_ptr + AW'(i)] == in_dest)) begin
        match_any = 1'b1;
        match_idx = rd_ptr + AW'(i);
      end
    end
  end

  // A head entry leaving this edge cannot absorb the request; it allocates instead.
  assign in_ready = !full || match_any;
  assign coal     = in_valid && in_ready && match_any && !(pop && (match_idx == rd_ptr));
`else
  assign in_ready = !full;
  assign coal     = 1'b0;
`endif

  assign push  = in_valid && in_ready && (in_dest != 4'd0) && !coal;
  assign empty = (count == '0) && !reg_write_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      reg_write_en   <= 1'b0;
      reg_write_dest <= 4'd0;
      reg_write_data <= 16'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr         <= rd_ptr + AW'(1);
        reg_write_en   <= 1'b1;
        reg_write_dest <= dest_q[rd_ptr];
        reg_write_data <= data_q[rd_ptr];
      end else begin
        reg_write_en <= 1'b0;
      end
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: count gates validity of every slot.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr] <= in_dest;
      data_q[wr_ptr] <= in_data;
    end
`ifdef WBQ_COALESCE_EN
    else if (coal) begin
      data_q[match_idx] <= in_data;
    end
`endif
  end

  // Walk oldest to youngest so younger matches override; in-flight output is lowest priority.
  function automatic logic [16:0] lookup(input logic [3:0] addr);
    logic [16:0] r;
    r = '0;
    if (addr != 4'd0) begin
      if (reg_write_en && (reg_write_dest == addr)) r = {1'b1, reg_write_data};
      for (int i = 0; i < DEPTH; i++) begin
        if (((AW+1)'(i) < count) && (dest_q[rd_ptr + AW'(i)] == addr))
          r = {1'b1, data_q[rd_ptr + AW'(i)]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {lookup_hit_1, lookup_data_1} = lookup(lookup_addr_1);
    {lookup_hit_2, lookup_data_2} = lookup(lookup_addr_2);
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, latency, ordering, bypass, reg0, mid-run reset, coalescing.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_dest;
  logic [15:0] in_data;
  logic        wb_hold;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  lookup_addr_1;
  logic        lookup_hit_1;
  logic [15:0] lookup_data_1;
  logic [3:0]  lookup_addr_2;
  logic        lookup_hit_2;
  logic [15:0] lookup_data_2;
  logic        empty;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [19:0] exp_q[$];

  wb_write_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .wb_hold(wb_hold),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .lookup_addr_1(lookup_addr_1), .lookup_hit_1(lookup_hit_1), .lookup_data_1(lookup_data_1),
    .lookup_addr_2(lookup_addr_2), .lookup_hit_2(lookup_hit_2), .lookup_data_2(lookup_data_2),
    .empty(empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [15:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_dest  = 4'd0;
    in_data  = 16'd0;
  endtask

  // scoreboard: current output must be the oldest expected write
  task automatic pop_check(input string tag);
    logic [19:0] e;
    check({tag, "_en"}, reg_write_en, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dest"}, reg_write_dest, e[19:16]);
      check({tag, "_data"}, reg_write_data, e[15:0]);
    end
  endtask

  task automatic drain_check(input string tag, input int cycles);
    for (int n = 0; n < cycles; n++) begin
      step();
      if (reg_write_en) pop_check(tag);
    end
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    wb_hold = 1'b0;
    lookup_addr_1 = 4'd0;
    lookup_addr_2 = 4'd0;
    idle();
    step();
    step();

    // reset values
    check("rst_ready", in_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_en", reg_write_en, 1'b0);
    check("rst_dest", reg_write_dest, 4'd0);
    check("rst_data", reg_write_data, 16'd0);
    rst = 1'b0;
    step();

    // single write latency
    drive(4'd3, 16'h1234);
    lookup_addr_1 = 4'd3;
    step();
    idle();
    check("lat1_en", reg_write_en, 1'b0);
    check("lat1_empty", empty, 1'b0);
    check("lat1_hit", lookup_hit_1, 1'b1);
    check("lat1_ldata", lookup_data_1, 16'h1234);
    step();
    check("lat2_en", reg_write_en, 1'b1);
    check("lat2_dest", reg_write_dest, 4'd3);
    check("lat2_data", reg_write_data, 16'h1234);
    check("lat2_inflight_hit", lookup_hit_1, 1'b1);
    step();
    check("lat3_en", reg_write_en, 1'b0);
    check("lat3_empty", empty, 1'b1);
    check("lat3_dest_hold", reg_write_dest, 4'd3);
    check("lat3_miss", lookup_hit_1, 1'b0);

    // hold, fill, stall, in-order drain
    wb_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(4'(k), 16'(k * 17));
      check("fill_ready", in_ready, 1'b1);
      exp_q.push_back({4'(k), 16'(k * 17)});
      step();
    end
    drive(4'd5, 16'h0055);
    check("full_ready", in_ready, 1'b0);
    step();
    check("full_stall_ready", in_ready, 1'b0);
    check("full_hold_en", reg_write_en, 1'b0);
    wb_hold = 1'b0;
    step();
    pop_check("drain_a");
    check("no_fallthrough_then_ready", in_ready, 1'b1);
    exp_q.push_back({4'd5, 16'h0055});
    step();
    idle();
    pop_check("drain_b");
    drain_check("drain", 5);

    // bypass: youngest of two writes to dest 5
    wb_hold = 1'b1;
    lookup_addr_1 = 4'd5;
    lookup_addr_2 = 4'd6;
    drive(4'd5, 16'h00AA);
    step();
    drive(4'd5, 16'h00BB);
    step();
    idle();
    check("byp_hit1", lookup_hit_1, 1'b1);
    check("byp_data1", lookup_data_1, 16'h00BB);
    check("byp_hit2", lookup_hit_2, 1'b0);
    check("byp_data2", lookup_data_2, 16'h0000);
    wb_hold = 1'b0;
    step();
    check("byp_after_pop_data", lookup_data_1, 16'h00BB);
    for (int n = 0; n < 4; n++) step();
    check("byp_done_empty", empty, 1'b1);

    // register 0 requests are accepted but dropped
    lookup_addr_1 = 4'd0;
    drive(4'd0, 16'hFFFF);
    check("r0_ready", in_ready, 1'b1);
    check("r0_lookup_hit", lookup_hit_1, 1'b0);
    step();
    idle();
    check("r0_empty", empty, 1'b1);
    step();
    check("r0_en", reg_write_en, 1'b0);
    check("r0_empty2", empty, 1'b1);
    check("r0_lookup_data", lookup_data_1, 16'h0000);

    // asynchronous reset with the queue half full
    wb_hold = 1'b1;
    lookup_addr_1 = 4'd8;
    drive(4'd8, 16'h0808);
    step();
    drive(4'd9, 16'h0909);
    step();
    idle();
    check("pre_rst_hit", lookup_hit_1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", in_ready, 1'b1);
    check("arst_empty", empty, 1'b1);
    check("arst_en", reg_write_en, 1'b0);
    check("arst_dest", reg_write_dest, 4'd0);
    check("arst_hit", lookup_hit_1, 1'b0);
    step();
    rst = 1'b0;
    wb_hold = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      check("post_rst_no_write", reg_write_en, 1'b0);
    end

    // full queue with dest 7 pending, then another dest 7 request
    wb_hold = 1'b1;
    drive(4'd7, 16'h0707); step();
    drive(4'd1, 16'h0101); step();
    drive(4'd2, 16'h0202); step();
    drive(4'd3, 16'h0303); step();
    drive(4'd7, 16'h0C0C);
`ifdef WBQ_COALESCE_EN
    check("coal_ready", in_ready, 1'b1);
    step();
    idle();
    in_dest = 4'd4;
    check("coal_still_full", in_ready, 1'b0);
    idle();
    exp_q.push_back({4'd7, 16'h0C0C});
    exp_q.push_back({4'd1, 16'h0101});
    exp_q.push_back({4'd2, 16'h0202});
    exp_q.push_back({4'd3, 16'h0303});
`else
    check("nocoal_ready", in_ready, 1'b0);
    step();
    idle();
    exp_q.push_back({4'd7, 16'h0707});
    exp_q.push_back({4'd1, 16'h0101});
    exp_q.push_back({4'd2, 16'h0202});
    exp_q.push_back({4'd3, 16'h0303});
`endif
    wb_hold = 1'b0;
    drain_check("coal_drain", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back queue that sits between the execute/memory stages and the 16x16 register file write port.
- Accepts register write requests through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains the FIFO one entry per cycle onto reg_write_en/reg_write_dest/reg_write_data, which connect directly to the register file.
- Provides two bypass lookups so the decode stage can see values that are pending but not yet written.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, range 2..16.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept a request.
- in_dest  input  4  destination register index.
- in_data  input  16  write data.
- wb_hold  input  1  when high, blocks draining to the register file.
- reg_write_en  output  1  register file write strobe (registered).
- reg_write_dest  output  4  register file write index (registered).
- reg_write_data  output  16  register file write data (registered).
- lookup_addr_1  input  4  bypass query 1.
- lookup_hit_1  output  1  a pending write exists for lookup_addr_1.
- lookup_data_1  output  16  youngest pending data for lookup_addr_1.
- lookup_addr_2  input  4  bypass query 2.
- lookup_hit_2  output  1  a pending write exists for lookup_addr_2.
- lookup_data_2  output  16  youngest pending data for lookup_addr_2.
- empty  output  1  FIFO count == 0 and reg_write_en == 0.

Behaviour:
- Clocking and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: count, read pointer and write pointer = 0; reg_write_en = 0, reg_write_dest = 0, reg_write_data = 0; in_ready = 1; empty = 1.
- Reset mid-operation discards all queued entries and any in-flight write.
- Handshake:
  - A request is accepted at a rising edge when in_valid && in_ready.
  - in_ready = (count < DEPTH), combinational from state only, independent of in_valid.
- Register 0 requests: in_dest == 0 is accepted whenever in_ready == 1 but never enqueued, because register 0 always reads as zero.
- Drain, per edge:
  - If count > 0 and wb_hold == 0: load the head entry into reg_write_dest/reg_write_data, set reg_write_en = 1, and pop.
  - Otherwise set reg_write_en = 0; dest and data hold their previous values.
- Latency: a request accepted at edge N with the queue empty drives reg_write_en during cycle N+1..N+2, and the register file captures it at edge N+2.
- Throughput: one write per cycle, back-to-back.
- Simultaneous push and pop: allowed; count is unchanged.
- Full queue: a pop in the same cycle does not raise in_ready, so there is no fall-through.
- Ordering: strictly in-order; writes to the same dest retire in acceptance order.
- Pointers: wrap modulo DEPTH.
- Bypass (combinational from stored state only; the same-cycle in_* request is never forwarded):
  - Candidates are all valid FIFO entries plus the in-flight output register when reg_write_en == 1.
  - Priority runs youngest FIFO entry, then older FIFO entries, then the in-flight output, lowest priority last.
  - lookup_addr == 0 gives hit = 0 and data = 0.
  - On a miss, data = 0.
- wb_hold: freezes draining only; acceptance continues until the queue is full.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- With the macro defined:
  - A request whose in_dest matches a valid FIFO entry overwrites that entry's data in place without allocating a new entry.
  - Such a request is accepted even when the queue is full, so in_ready = (count < DEPTH) || match on in_dest.
  - If the matching entry is the head and is being popped at the same edge, the request allocates normally instead.
  - The in-flight output register is never coalesced into.
- Without the macro: every nonzero-dest request allocates its own entry, and duplicate dests may coexist in the queue.

Test Plan:
- Reset, then push (dest 3, data 0x1234) at edge 1 -> reg_write_en=1, dest=3, data=0x1234 in cycle after edge 2; empty=1 after edge 3.
- wb_hold=1, push dest 1..5 with data 0x0011..0x0055 -> in_ready drops after 4 accepts and the 5th is stalled; release hold -> four writes in order 1,2,3,4, then dest 5.
- wb_hold=1, push (5,0x00AA) then (5,0x00BB) -> lookup_addr_1=5 gives hit=1, data=0x00BB; lookup_addr_2=6 gives hit=0, data=0.
- Push (0,0xFFFF) -> accepted, reg_write_en stays 0, count stays 0; lookup_addr_1=0 gives hit=0.
- Queue half full, assert rst between edges -> all outputs return to reset values immediately and in_ready=1; no stale write appears.
- With WBQ_COALESCE_EN defined: queue full with dest 7 present, push (7,0x0C0C) -> accepted, count stays 4, and the drained dest 7 write carries 0x0C0C.
